// File: rtl/fir_pkg.sv
// Shared constants for the streaming FIR engine: state encoding, default tap
// count and the word-to-byte address scale.
package fir_pkg;

  localparam int unsigned TAPE_NUM_DEF = 11;
  localparam int unsigned WORD_BYTES   = 4;
  localparam int unsigned ST_W         = 3;

  localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] S_CLEAR   = 3'd1;
  localparam logic [ST_W-1:0] S_WAIT_IN = 3'd2;
  localparam logic [ST_W-1:0] S_MAC     = 3'd3;
  localparam logic [ST_W-1:0] S_OUT     = 3'd4;

endpackage

// File: rtl/fir_mac.sv
// Registered multiply-accumulate: two's-complement product truncated to W bits,
// wrap-around accumulation, synchronous clear.
module fir_mac #(
  parameter int unsigned W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + a * b;
    end
  end

endmodule

// File: rtl/fir_stream_engine.sv
// Streaming FIR engine: one input sample per frame step, Tape_Num-cycle MAC over
// tap and circular data BRAMs, AXI-Stream in/out with ap_done/ap_idle status.
module fir_stream_engine
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = TAPE_NUM_DEF
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic                   ap_done_clr,
  output logic                   ap_done,
  output logic                   ap_idle,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic                   ss_tlast,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic                   sm_tlast,
  output logic                   tap_rd_EN,
  output logic [pADDR_WIDTH-1:0] tap_rd_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam int unsigned CNT_W = $clog2(Tape_Num + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(Tape_Num - 1);
  localparam logic [CNT_W-1:0] NUM      = CNT_W'(Tape_Num);

  logic [ST_W-1:0]  state, next_state;
  logic [CNT_W-1:0] cnt, wr_ptr, data_idx;
  logic             last_q, accept, mac_en, done_set, ap_done_nxt;
  logic [pDATA_WIDTH-1:0] acc;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [CNT_W-1:0] idx);
    return pADDR_WIDTH'(32'(idx) * WORD_BYTES);
  endfunction

  assign accept   = ss_tready && ss_tvalid;
  assign mac_en   = (state == S_MAC) && (cnt != '0);
  assign done_set = (state == S_OUT) && sm_tready && sm_tlast;
  assign sm_tdata = acc;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next state, status-next and BRAM port drive; BRAM ports follow the state directly.
  always_comb begin
    next_state  = state;
    ap_done_nxt = ap_done;
    tap_rd_EN   = 1'b0;
    tap_rd_A    = '0;
    data_EN     = 1'b0;
    data_WE     = 4'h0;
    data_Di     = '0;
    data_A      = '0;
    data_idx    = (wr_ptr >= cnt) ? (wr_ptr - cnt) : (wr_ptr + NUM - cnt);
    if (done_set)         ap_done_nxt = 1'b1;
    else if (ap_done_clr) ap_done_nxt = 1'b0;
    case (state)
      S_IDLE: if (ap_start) next_state = S_CLEAR;
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hf;
        data_A  = word_addr(cnt);
        if (cnt == LAST_IDX) next_state = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        if (accept) begin
          data_EN    = 1'b1;
          data_WE    = 4'hf;
          data_Di    = ss_tdata;
          data_A     = word_addr(wr_ptr);
          next_state = S_MAC;
        end
      end
      S_MAC: begin
        if (cnt < NUM) begin
          tap_rd_EN = 1'b1;
          tap_rd_A  = word_addr(cnt);
          data_EN   = 1'b1;
          data_A    = word_addr(data_idx);
        end
        if (cnt == NUM) next_state = S_OUT;
      end
      S_OUT: if (sm_tready) next_state = sm_tlast ? S_IDLE : S_WAIT_IN;
      default: next_state = S_IDLE;
    endcase
  end

  // Step counter shared by CLEAR (word index) and MAC (read index / product slot).
  always_ff @(posedge axis_clk) begin
    if (axis_rst || (state != next_state)) cnt <= '0;
    else if ((state == S_CLEAR) || (state == S_MAC)) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst || (state == S_CLEAR)) begin
      wr_ptr <= '0;
    end else if ((state == S_MAC) && (next_state == S_OUT)) begin
      wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      last_q    <= 1'b0;
      ap_done   <= 1'b0;
      ap_idle   <= 1'b1;
      ss_tready <= 1'b0;
      sm_tvalid <= 1'b0;
      sm_tlast  <= 1'b0;
    end else begin
      if (accept) last_q <= ss_tlast;
      ap_done   <= ap_done_nxt;
      ap_idle   <= (next_state == S_IDLE) && !ap_done_nxt;
      ss_tready <= (next_state == S_WAIT_IN);
      sm_tvalid <= (next_state == S_OUT);
      sm_tlast  <= (next_state == S_OUT) && last_q;
    end
  end

  fir_mac #(.W(pDATA_WIDTH)) u_mac (
    .clk (axis_clk),
    .rst (axis_rst),
    .clr (accept),
    .en  (mac_en),
    .a   (tap_Do),
    .b   (data_Do),
    .acc (acc)
  );

endmodule

// File: tb/tb_fir_stream_engine.sv
// Directed bench for fir_stream_engine with behavioural 1-cycle-latency BRAMs.
module tb_fir_stream_engine;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NT = 11;

  logic          axis_clk = 1'b0;
  logic          axis_rst = 1'b1;
  logic          ap_start = 1'b0, ap_done_clr = 1'b0;
  logic          ap_done, ap_idle;
  logic [DW-1:0] ss_tdata = '0;
  logic          ss_tvalid = 1'b0, ss_tlast = 1'b0, ss_tready;
  logic [DW-1:0] sm_tdata;
  logic          sm_tvalid, sm_tlast;
  logic          sm_tready = 1'b1;
  logic          tap_rd_EN, data_EN;
  logic [AW-1:0] tap_rd_A, data_A;
  logic [DW-1:0] tap_Do, data_Do, data_Di;
  logic [3:0]    data_WE;

  logic [DW-1:0] tap_mem  [NT];
  logic [DW-1:0] data_mem [NT];
  logic [DW-1:0] stim     [600];
  logic [DW-1:0] got      [600];
  logic          got_last [600];
  int            lat0;
  int            n_cmp = 0, n_bad = 0;

  always #5 axis_clk = ~axis_clk;

  fir_stream_engine #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .ap_start(ap_start), .ap_done_clr(ap_done_clr),
    .ap_done(ap_done), .ap_idle(ap_idle),
    .ss_tdata(ss_tdata), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tlast(ss_tlast),
    .sm_tdata(sm_tdata), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .tap_rd_EN(tap_rd_EN), .tap_rd_A(tap_rd_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do)
  );

  always @(posedge axis_clk) begin
    if (tap_rd_EN) tap_Do <= tap_mem[tap_rd_A[AW-1:2]];
    if (data_EN) begin
      data_Do <= data_mem[data_A[AW-1:2]];
      if (data_WE == 4'hf) data_mem[data_A[AW-1:2]] <= data_Di;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_impulse_taps();
    int t [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int i = 0; i < int'(NT); i++) tap_mem[i] = DW'(t[i]);
  endtask

  task automatic pulse_start();
    ap_start = 1'b1;
    @(negedge axis_clk);
    ap_start = 1'b0;
  endtask

  // Drives one sample, waits for its output, optionally back-pressures or clears ap_done at the handshake.
  task automatic send(input int k, input logic last, input int bp, input logic clr_hs);
    int wt;
    logic [DW-1:0] d0;
    logic stable, rdy_seen;
    wt = 0;
    while (!ss_tready && wt < 40) begin @(negedge axis_clk); wt++; end
    if (!ss_tready) begin chk("ss_tready_timeout", 32'(ss_tready), 32'd1); return; end
    ss_tvalid = 1'b1; ss_tdata = stim[k]; ss_tlast = last;
    @(negedge axis_clk);
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
    wt = 1;
    while (!sm_tvalid && wt < 40) begin @(negedge axis_clk); wt++; end
    if (!sm_tvalid) begin chk("sm_tvalid_timeout", 32'(sm_tvalid), 32'd1); return; end
    if (k == 0) lat0 = wt;
    if (bp > 0) begin
      sm_tready = 1'b0;
      d0 = sm_tdata; stable = 1'b1; rdy_seen = 1'b0;
      repeat (bp) begin
        @(negedge axis_clk);
        if (sm_tdata !== d0 || !sm_tvalid) stable = 1'b0;
        if (ss_tready) rdy_seen = 1'b1;
      end
      chk("bp_data_stable", 32'(stable), 32'd1);
      chk("bp_ss_tready_low", 32'(rdy_seen), 32'd0);
      sm_tready = 1'b1;
    end
    got[k] = sm_tdata; got_last[k] = sm_tlast;
    ap_done_clr = clr_hs;
    @(negedge axis_clk);
    ap_done_clr = 1'b0;
  endtask

  task automatic run_frame(input int n, input int bp_idx, input int clr_idx);
    pulse_start();
    for (int k = 0; k < n; k++) send(k, k == n - 1, (k == bp_idx) ? 20 : 0, k == clr_idx);
  endtask

  task automatic check_impulse(input string tag);
    int t [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int i = 0; i < int'(NT); i++) chk($sformatf("%s_y%0d", tag, i), got[i], DW'(t[i]));
    chk({tag, "_tlast_first"}, 32'(got_last[0]), 32'd0);
    chk({tag, "_tlast_end"}, 32'(got_last[NT-1]), 32'd1);
  endtask

  task automatic clr_done();
    ap_done_clr = 1'b1;
    @(negedge axis_clk);
    ap_done_clr = 1'b0;
  endtask

  initial begin
    int t [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    logic [DW-1:0] y;
    logic seen_v;
    logic tl_ok;
    repeat (3) @(negedge axis_clk);
    chk("rst_ap_idle", 32'(ap_idle), 32'd1);
    chk("rst_ap_done", 32'(ap_done), 32'd0);
    chk("rst_ss_tready", 32'(ss_tready), 32'd0);
    chk("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    chk("rst_sm_tlast", 32'(sm_tlast), 32'd0);
    chk("rst_sm_tdata", sm_tdata, 32'd0);
    axis_rst = 1'b0;
    @(negedge axis_clk);

    // Impulse response.
    load_impulse_taps();
    for (int i = 0; i < int'(NT); i++) stim[i] = (i == 0) ? 32'd1 : 32'd0;
    run_frame(NT, -1, -1);
    check_impulse("imp");
    chk("latency", 32'(lat0), 32'(NT + 2));
    chk("imp_ap_done", 32'(ap_done), 32'd1);
    chk("imp_ap_idle_busy", 32'(ap_idle), 32'd0);
    clr_done();
    chk("imp_ap_done_clr", 32'(ap_done), 32'd0);

    // Wrap-around accumulation with set/clear collision on the final handshake.
    for (int i = 0; i < int'(NT); i++) tap_mem[i] = 32'd1;
    stim[0] = 32'h7FFF_FFFF; stim[1] = 32'h7FFF_FFFF;
    run_frame(2, -1, 1);
    chk("wrap_y0", got[0], 32'h7FFF_FFFF);
    chk("wrap_y1", got[1], 32'hFFFF_FFFE);
    chk("done_set_wins", 32'(ap_done), 32'd1);
    clr_done();
    chk("done_lone_clr", 32'(ap_done), 32'd0);
    chk("idle_after_clr", 32'(ap_idle), 32'd1);

    // Back-pressure on the fourth output.
    load_impulse_taps();
    for (int i = 0; i < int'(NT); i++) stim[i] = (i == 0) ? 32'd1 : 32'd0;
    run_frame(NT, 3, -1);
    check_impulse("bp");
    clr_done();

    // Reset during MAC aborts the frame.
    stim[0] = 32'd1;
    pulse_start();
    repeat (40) if (!ss_tready) @(negedge axis_clk);
    ss_tvalid = 1'b1; ss_tdata = 32'd1;
    @(negedge axis_clk);
    ss_tvalid = 1'b0;
    repeat (4) @(negedge axis_clk);
    axis_rst = 1'b1;
    @(negedge axis_clk);
    axis_rst = 1'b0;
    chk("mid_rst_ap_idle", 32'(ap_idle), 32'd1);
    seen_v = 1'b0;
    repeat (20) begin
      if (sm_tvalid) seen_v = 1'b1;
      @(negedge axis_clk);
    end
    chk("mid_rst_no_tvalid", 32'(seen_v), 32'd0);
    for (int i = 0; i < int'(NT); i++) stim[i] = (i == 0) ? 32'd1 : 32'd0;
    run_frame(NT, -1, -1);
    check_impulse("post_rst");
    clr_done();

    // Ramp 0..599 against a direct-form golden model.
    for (int i = 0; i < 600; i++) stim[i] = DW'(i);
    run_frame(600, -1, -1);
    chk("ramp_y2", got[2], 32'hFFFF_FFF6);
    chk("ramp_y3", got[3], 32'hFFFF_FFE3);
    tl_ok = 1'b1;
    for (int n = 0; n < 600; n++) begin
      y = '0;
      for (int i = 0; i < int'(NT); i++) if (n - i >= 0) y = y + DW'(t[i]) * stim[n-i];
      chk($sformatf("ramp_y%0d", n), got[n], y);
      if (got_last[n] !== (n == 599)) tl_ok = 1'b0;
    end
    chk("ramp_tlast_only_last", 32'(tl_ok), 32'd1);
    chk("ramp_ap_done", 32'(ap_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
